tile_map_addresser: RTL and testbench

- Upstream stage of the per-tile renderer.
- Converts the VGA pixel stream (pixelX/pixelY) into a tile type plus in-tile offsets, using a 10x15 map of 64x32-pixel tiles held in registers.
- After reset or level restart, loads a default level pattern. Game logic can then rewrite individual tiles (e.g. gift collected).
- Tracks how many gift tiles remain.

---
 rtl/tile_map_addresser_if.sv | 11 +
 rtl/tile_map_addresser.sv | 182 ++++++++++++++++++
 tb/tb_tile_map_addresser.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_map_addresser_if.sv
// Tile write handshake between game logic (master) and the tile map addresser (slave).
interface tile_map_addresser_if;
  logic       wrReq;
  logic [3:0] wrCol;
  logic [3:0] wrRow;
  logic [1:0] wrType;
  logic       wrAck;

  modport master (output wrReq, output wrCol, output wrRow, output wrType, input wrAck);
  modport slave  (input wrReq, input wrCol, input wrRow, input wrType, output wrAck);
endinterface

// File: rtl/tile_map_addresser.sv
// Maps the VGA pixel stream onto a register-held tile map, and serves tile rewrites
// from game logic while tracking how many gift tiles remain.
module tile_map_addresser #(
  parameter int unsigned TILE_W_BITS = 6,
  parameter int unsigned TILE_H_BITS = 5,
  parameter int unsigned MAP_COLS    = 10,
  parameter int unsigned MAP_ROWS    = 15
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic [10:0]            pixelX,
  input  logic [10:0]            pixelY,
  input  logic                   levelRestart,
  tile_map_addresser_if.slave    wr,
  output logic [10:0]            offsetX,
  output logic [10:0]            offsetY,
  output logic [1:0]             Tile_type,
  output logic                   insideMap,
  output logic                   initDone,
  output logic [7:0]             giftsRemaining,
  output logic                   allGiftsTaken
);

  localparam int unsigned MapSize = MAP_COLS * MAP_ROWS;
  localparam int unsigned IdxW    = $clog2(MapSize);

  localparam logic [1:0] TileBg    = 2'b00;
  localparam logic [1:0] TileFloor = 2'b01;
  localparam logic [1:0] TileGift  = 2'b10;

  localparam logic [IdxW-1:0] MapColsIdx   = IdxW'(MAP_COLS);
  localparam logic [IdxW-1:0] LastIdx      = IdxW'(MapSize - 1);
  localparam logic [IdxW-1:0] FloorRowBase = IdxW'((MAP_ROWS - 1) * MAP_COLS);
  localparam logic [IdxW-1:0] LedgeLo      = IdxW'(10 * MAP_COLS + 2);
  localparam logic [IdxW-1:0] LedgeHi      = IdxW'(10 * MAP_COLS + 7);
  localparam logic [IdxW-1:0] GiftA        = IdxW'(9 * MAP_COLS + 3);
  localparam logic [IdxW-1:0] GiftB        = IdxW'(9 * MAP_COLS + 6);
  localparam logic [7:0]      DefaultGifts = 8'd2;

  localparam logic [10:0] XLimit   = 11'(MAP_COLS << TILE_W_BITS);
  localparam logic [10:0] YLimit   = 11'(MAP_ROWS << TILE_H_BITS);
  localparam logic [10:0] OffXMask = 11'((1 << TILE_W_BITS) - 1);
  localparam logic [10:0] OffYMask = 11'((1 << TILE_H_BITS) - 1);
  localparam logic [3:0]  ColLimit = 4'(MAP_COLS);
  localparam logic [3:0]  RowLimit = 4'(MAP_ROWS);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  // Default level: floor along the bottom row, a ledge on row 10, two gifts above it.
  function automatic logic [1:0] default_tile(input logic [IdxW-1:0] idx);
    if (idx >= FloorRowBase)                return TileFloor;
    if ((idx >= LedgeLo) && (idx <= LedgeHi)) return TileFloor;
    if ((idx == GiftA) || (idx == GiftB))   return TileGift;
    return TileBg;
  endfunction

  state_e            state_q, state_d;
  logic [IdxW-1:0]   init_cnt_q, init_cnt_d;
  logic              init_done_q, init_done_d;
  logic [7:0]        gifts_q, gifts_d;
  logic              wr_ack_q, wr_ack_d;
  logic [1:0]        map_q [MapSize];

  logic              map_we;
  logic [IdxW-1:0]   map_widx;
  logic [1:0]        map_wdata;

  logic [10:0]       offset_x_q, offset_y_q;
  logic [1:0]        tile_q;
  logic              inside_q;

  // Pixel address decode
  logic [IdxW-1:0]   px_col, px_row, rd_idx;
  logic              px_inside;

  assign px_col    = IdxW'(pixelX >> TILE_W_BITS);
  assign px_row    = IdxW'(pixelY >> TILE_H_BITS);
  assign px_inside = (pixelX < XLimit) && (pixelY < YLimit);
  assign rd_idx    = px_inside ? (px_row * MapColsIdx + px_col) : '0;

  // Write address decode; out-of-range requests are acked but never touch the map
  logic              wr_in_range;
  logic [IdxW-1:0]   wr_idx;
  logic [1:0]        wr_old;

  assign wr_in_range = (wr.wrCol < ColLimit) && (wr.wrRow < RowLimit);
  assign wr_idx      = wr_in_range ? (IdxW'(wr.wrRow) * MapColsIdx + IdxW'(wr.wrCol)) : '0;
  assign wr_old      = map_q[wr_idx];

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    gifts_d     = gifts_q;
    wr_ack_d    = 1'b0;
    map_we      = 1'b0;
    map_widx    = init_cnt_q;
    map_wdata   = default_tile(init_cnt_q);

    unique case (state_q)
      StInit: begin
        if (levelRestart) begin
          init_cnt_d = '0;
        end else begin
          map_we = 1'b1;
          if (init_cnt_q == LastIdx) begin
            state_d     = StRun;
            init_cnt_d  = '0;
            init_done_d = 1'b1;
            gifts_d     = DefaultGifts;
          end else begin
            init_cnt_d = init_cnt_q + 1'b1;
          end
        end
      end
      StRun: begin
        if (levelRestart) begin
          // Restart wins over a coincident write; the request stays pending until RUN
          state_d     = StInit;
          init_cnt_d  = '0;
          init_done_d = 1'b0;
          gifts_d     = '0;
        end else if (wr.wrReq) begin
          wr_ack_d = 1'b1;
          if (wr_in_range) begin
            map_we    = 1'b1;
            map_widx  = wr_idx;
            map_wdata = wr.wrType;
            if ((wr_old == TileGift) && (wr.wrType != TileGift) && (gifts_q != 8'd0)) begin
              gifts_d = gifts_q - 8'd1;
            end else if ((wr_old != TileGift) && (wr.wrType == TileGift) &&
                         (gifts_q != 8'hFF)) begin
              gifts_d = gifts_q + 8'd1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= StInit;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      gifts_q     <= '0;
      wr_ack_q    <= 1'b0;
      offset_x_q  <= '0;
      offset_y_q  <= '0;
      tile_q      <= TileBg;
      inside_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      gifts_q     <= gifts_d;
      wr_ack_q    <= wr_ack_d;
      inside_q    <= px_inside;
      offset_x_q  <= px_inside ? (pixelX & OffXMask) : '0;
      offset_y_q  <= px_inside ? (pixelY & OffYMask) : '0;
      // Reads the pre-write contents, so a same-cycle rewrite shows up one cycle later
      tile_q      <= (px_inside && (state_q == StRun)) ? map_q[rd_idx] : TileBg;
    end
  end

  // Map storage is left unreset; INIT overwrites every entry before it is used
  always_ff @(posedge clk) begin
    if (map_we) begin
      map_q[map_widx] <= map_wdata;
    end
  end

  assign wr.wrAck       = wr_ack_q;
  assign offsetX        = offset_x_q;
  assign offsetY        = offset_y_q;
  assign Tile_type      = tile_q;
  assign insideMap      = inside_q;
  assign initDone       = init_done_q;
  assign giftsRemaining = gifts_q;
  assign allGiftsTaken  = init_done_q && (gifts_q == 8'd0);

endmodule

// File: tb/tb_tile_map_addresser.sv
// Scoreboard bench for tile_map_addresser: expected pixel results and gift counts are
// queued when stimulus is driven and popped when the DUT responds.
module tb_tile_map_addresser;

  logic        clk = 1'b0;
  logic        resetN;
  logic [10:0] pixelX, pixelY;
  logic        levelRestart;
  logic [10:0] offsetX, offsetY;
  logic [1:0]  Tile_type;
  logic        insideMap, initDone, allGiftsTaken;
  logic [7:0]  giftsRemaining;

  tile_map_addresser_if wr_if ();

  tile_map_addresser dut (
    .clk           (clk),
    .resetN        (resetN),
    .pixelX        (pixelX),
    .pixelY        (pixelY),
    .levelRestart  (levelRestart),
    .wr            (wr_if),
    .offsetX       (offsetX),
    .offsetY       (offsetY),
    .Tile_type     (Tile_type),
    .insideMap     (insideMap),
    .initDone      (initDone),
    .giftsRemaining(giftsRemaining),
    .allGiftsTaken (allGiftsTaken)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  tt;
    logic [10:0] ox;
    logic [10:0] oy;
    logic        in_map;
  } pix_t;

  pix_t       pix_q[$];
  logic [7:0] gift_q[$];
  logic [1:0] exp_map [150];
  logic [7:0] exp_gifts;
  bit         model_run;
  int         n_pass = 0;
  int         n_total = 0;

  function automatic void model_load();
    exp_gifts = 8'd0;
    for (int r = 0; r < 15; r++) begin
      for (int c = 0; c < 10; c++) begin
        logic [1:0] t;
        t = 2'b00;
        if (r == 14) t = 2'b01;
        if (r == 10 && c >= 2 && c <= 7) t = 2'b01;
        if (r == 9 && (c == 3 || c == 6)) t = 2'b10;
        if (t == 2'b10) exp_gifts = exp_gifts + 8'd1;
        exp_map[r * 10 + c] = t;
      end
    end
  endfunction

  function automatic pix_t model_pixel(input int x, input int y);
    pix_t p;
    p = '0;
    if (x < 640 && y < 480) begin
      p.in_map = 1'b1;
      p.ox     = 11'(x % 64);
      p.oy     = 11'(y % 32);
      if (model_run) p.tt = exp_map[(y / 32) * 10 + x / 64];
    end
    return p;
  endfunction

  function automatic logic [7:0] model_write(input int c, input int r, input logic [1:0] t);
    if (c < 10 && r < 15) begin
      logic [1:0] old;
      old = exp_map[r * 10 + c];
      if (old == 2'b10 && t != 2'b10 && exp_gifts != 8'd0) exp_gifts = exp_gifts - 8'd1;
      else if (old != 2'b10 && t == 2'b10 && exp_gifts != 8'hFF) exp_gifts = exp_gifts + 8'd1;
      exp_map[r * 10 + c] = t;
    end
    return exp_gifts;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pixel(input int x, input int y);
    pixelX = 11'(x);
    pixelY = 11'(y);
    step();
  endtask

  task automatic drive_write(input int c, input int r, input logic [1:0] t,
                             output bit acked, output int waited);
    wr_if.wrReq  = 1'b1;
    wr_if.wrCol  = 4'(c);
    wr_if.wrRow  = 4'(r);
    wr_if.wrType = t;
    acked  = 1'b0;
    waited = 0;
    while (!acked && waited < 400) begin
      step();
      waited++;
      if (wr_if.wrAck === 1'b1) acked = 1'b1;
    end
    wr_if.wrReq = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    levelRestart = 1'b0;
    wr_if.wrReq = 1'b0;
    wr_if.wrCol = '0;
    wr_if.wrRow = '0;
    wr_if.wrType = '0;
    pixelX = 11'd200;
    pixelY = 11'd300;
    repeat (3) step();
    n_total++;
    if ({initDone, giftsRemaining, Tile_type, insideMap, offsetX, offsetY, wr_if.wrAck,
         allGiftsTaken} !== '0)
      $display("FAIL reset_outputs: got initDone=%b gifts=%0d tile=%b inside=%b offX=%0d offY=%0d ack=%b all=%b, want all 0",
               initDone, giftsRemaining, Tile_type, insideMap, offsetX, offsetY, wr_if.wrAck,
               allGiftsTaken);
    else n_pass++;
  endtask

  task automatic test_init_timing();
    int n;
    resetN = 1'b1;
    n = 0;
    while (initDone !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    n_total++;
    if (n !== 150) $display("FAIL init_latency: got %0d cycles, want 150", n);
    else n_pass++;
    n_total++;
    if (giftsRemaining !== 8'd2) $display("FAIL init_gifts: got %0d, want 2", giftsRemaining);
    else n_pass++;
    n_total++;
    if (allGiftsTaken !== 1'b0) $display("FAIL init_all_taken: got %b, want 0", allGiftsTaken);
    else n_pass++;
    model_load();
    model_run = 1'b1;
  endtask

  task automatic test_pixel();
    int xs[6] = '{200, 700, 639, 640, 0, 130};
    int ys[6] = '{300, 10, 479, 0, 480, 330};
    for (int i = 0; i < 6; i++) begin
      pix_t e;
      pix_q.push_back(model_pixel(xs[i], ys[i]));
      drive_pixel(xs[i], ys[i]);
      e = pix_q.pop_front();
      n_total++;
      if ({Tile_type, offsetX, offsetY, insideMap} !== e)
        $display("FAIL pixel(%0d,%0d): got tile=%b offX=%0d offY=%0d inside=%b, want tile=%b offX=%0d offY=%0d inside=%b",
                 xs[i], ys[i], Tile_type, offsetX, offsetY, insideMap, e.tt, e.ox, e.oy, e.in_map);
      else n_pass++;
    end
  endtask

  task automatic test_gift_writes();
    int cs[3] = '{3, 6, 0};
    int rs[3] = '{9, 9, 0};
    bit alls[3] = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      bit acked;
      int waited;
      logic [7:0] eg;
      gift_q.push_back(model_write(cs[i], rs[i], 2'b00));
      drive_write(cs[i], rs[i], 2'b00, acked, waited);
      eg = gift_q.pop_front();
      n_total++;
      if (!acked || waited != 1)
        $display("FAIL gift_write_ack%0d: acked=%b after %0d cycles, want ack after 1", i, acked, waited);
      else n_pass++;
      n_total++;
      if (giftsRemaining !== eg) $display("FAIL gift_write_count%0d: got %0d, want %0d", i, giftsRemaining, eg);
      else n_pass++;
      n_total++;
      if (allGiftsTaken !== alls[i])
        $display("FAIL gift_write_all%0d: got %b, want %b", i, allGiftsTaken, alls[i]);
      else n_pass++;
      step();
      n_total++;
      if (wr_if.wrAck !== 1'b0) $display("FAIL gift_write_pulse%0d: ack got %b, want 0", i, wr_if.wrAck);
      else n_pass++;
    end
  endtask

  task automatic test_out_of_range();
    int cs[2] = '{12, 0};
    int rs[2] = '{2, 15};
    pix_t e;
    for (int i = 0; i < 2; i++) begin
      bit acked;
      int waited;
      logic [7:0] eg;
      gift_q.push_back(model_write(cs[i], rs[i], 2'b10));
      drive_write(cs[i], rs[i], 2'b10, acked, waited);
      eg = gift_q.pop_front();
      n_total++;
      if (!acked || waited != 1)
        $display("FAIL oor_ack%0d: acked=%b after %0d cycles, want ack after 1", i, acked, waited);
      else n_pass++;
      n_total++;
      if (giftsRemaining !== eg) $display("FAIL oor_count%0d: got %0d, want %0d", i, giftsRemaining, eg);
      else n_pass++;
      step();
    end
    // col 12 row 2 would alias onto col 2 row 3 with an unchecked index
    pix_q.push_back(model_pixel(129, 97));
    drive_pixel(129, 97);
    e = pix_q.pop_front();
    n_total++;
    if (Tile_type !== e.tt) $display("FAIL oor_alias_tile: got %b, want %b", Tile_type, e.tt);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    wr_if.wrReq  = 1'b1;
    wr_if.wrCol  = 4'd1;
    wr_if.wrRow  = 4'd1;
    wr_if.wrType = 2'b10;
    gift_q.push_back(model_write(1, 1, 2'b10));
    gift_q.push_back(model_write(1, 1, 2'b10));
    for (int i = 0; i < 2; i++) begin
      logic [7:0] eg;
      step();
      eg = gift_q.pop_front();
      n_total++;
      if (wr_if.wrAck !== 1'b1) $display("FAIL b2b_ack%0d: got %b, want 1", i, wr_if.wrAck);
      else n_pass++;
      n_total++;
      if (giftsRemaining !== eg) $display("FAIL b2b_count%0d: got %0d, want %0d", i, giftsRemaining, eg);
      else n_pass++;
    end
    wr_if.wrReq = 1'b0;
    step();
    n_total++;
    if (wr_if.wrAck !== 1'b0) $display("FAIL b2b_release: ack got %b, want 0", wr_if.wrAck);
    else n_pass++;
  endtask

  task automatic test_restart();
    int n;
    int bad;
    pix_t e;
    pixelX = 11'd200;
    pixelY = 11'd300;
    levelRestart = 1'b1;
    step();
    levelRestart = 1'b0;
    n_total++;
    if ({initDone, giftsRemaining} !== 9'd0)
      $display("FAIL restart_clear: got initDone=%b gifts=%0d, want 0 and 0", initDone, giftsRemaining);
    else n_pass++;
    n = 0;
    bad = 0;
    while (initDone !== 1'b1 && n < 400) begin
      step();
      n++;
      if (initDone !== 1'b1 && (Tile_type !== 2'b00 || insideMap !== 1'b1)) bad++;
    end
    n_total++;
    if (n !== 150) $display("FAIL restart_latency: got %0d cycles, want 150", n);
    else n_pass++;
    n_total++;
    if (bad !== 0) $display("FAIL restart_tile_blank: %0d reload cycles with tile!=00 or outside, want 0", bad);
    else n_pass++;
    model_load();
    n_total++;
    if (giftsRemaining !== exp_gifts) $display("FAIL restart_gifts: got %0d, want %0d", giftsRemaining, exp_gifts);
    else n_pass++;
    pix_q.push_back(model_pixel(200, 300));
    drive_pixel(200, 300);
    e = pix_q.pop_front();
    n_total++;
    if (Tile_type !== e.tt) $display("FAIL restart_gift_tile: got %b, want %b", Tile_type, e.tt);
    else n_pass++;
  endtask

  task automatic test_write_during_init();
    int waited;
    int acks;
    bit done_at_ack;
    logic [7:0] eg;
    levelRestart = 1'b1;
    wr_if.wrReq  = 1'b1;
    wr_if.wrCol  = 4'd6;
    wr_if.wrRow  = 4'd9;
    wr_if.wrType = 2'b00;
    step();
    levelRestart = 1'b0;
    n_total++;
    if (wr_if.wrAck !== 1'b0) $display("FAIL init_hold_restart_ack: got %b, want 0", wr_if.wrAck);
    else n_pass++;
    model_load();
    gift_q.push_back(model_write(6, 9, 2'b00));
    waited = 0;
    acks = 0;
    done_at_ack = 1'b0;
    while (acks == 0 && waited < 400) begin
      step();
      waited++;
      if (wr_if.wrAck === 1'b1) begin
        acks++;
        done_at_ack = initDone;
      end
    end
    wr_if.wrReq = 1'b0;
    eg = gift_q.pop_front();
    n_total++;
    if (acks != 1 || waited != 151)
      $display("FAIL init_hold_ack: %0d acks after %0d cycles, want 1 after 151", acks, waited);
    else n_pass++;
    n_total++;
    if (done_at_ack !== 1'b1) $display("FAIL init_hold_done: initDone at ack got %b, want 1", done_at_ack);
    else n_pass++;
    n_total++;
    if (giftsRemaining !== eg) $display("FAIL init_hold_count: got %0d, want %0d", giftsRemaining, eg);
    else n_pass++;
    step();
    n_total++;
    if (wr_if.wrAck !== 1'b0) $display("FAIL init_hold_single: ack got %b, want 0", wr_if.wrAck);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    pix_t e;
    logic [7:0] eg;
    pix_q.push_back(model_pixel(5, 451));
    gift_q.push_back(model_write(0, 14, 2'b10));
    wr_if.wrReq  = 1'b1;
    wr_if.wrCol  = 4'd0;
    wr_if.wrRow  = 4'd14;
    wr_if.wrType = 2'b10;
    drive_pixel(5, 451);
    wr_if.wrReq = 1'b0;
    e = pix_q.pop_front();
    eg = gift_q.pop_front();
    n_total++;
    if (wr_if.wrAck !== 1'b1) $display("FAIL same_cycle_ack: got %b, want 1", wr_if.wrAck);
    else n_pass++;
    n_total++;
    if ({Tile_type, offsetX, offsetY, insideMap} !== e)
      $display("FAIL same_cycle_old: got tile=%b offX=%0d offY=%0d, want tile=%b offX=%0d offY=%0d",
               Tile_type, offsetX, offsetY, e.tt, e.ox, e.oy);
    else n_pass++;
    n_total++;
    if (giftsRemaining !== eg) $display("FAIL same_cycle_count: got %0d, want %0d", giftsRemaining, eg);
    else n_pass++;
    pix_q.push_back(model_pixel(5, 451));
    drive_pixel(5, 451);
    e = pix_q.pop_front();
    n_total++;
    if (Tile_type !== e.tt) $display("FAIL same_cycle_new: got %b, want %b", Tile_type, e.tt);
    else n_pass++;
  endtask

  initial begin
    model_run = 1'b0;
    test_reset();
    test_init_timing();
    test_pixel();
    test_gift_writes();
    test_out_of_range();
    test_back_to_back();
    test_restart();
    test_write_during_init();
    test_same_cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded 100000 time units, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
